cyp_ep6_wr: RTL and testbench
=============================

CYP_EP6_WR -- requirements
Module: cyp_ep6_wr

Interface
REQ-001 SHALL have parameter PKT_WORDS, default 256: 16-bit words per full USB packet (512 bytes), range 2..256.
REQ-002 SHALL have parameter FLUSH_TIMEOUT, default 1024: idle cycles before a short packet is committed, range 2..65535.
REQ-003 SHALL have port cyp_clk  input  1: 48 MHz clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset; asynchronous and active-low.
REQ-005 SHALL have port tx_en  input  1: enable; 1 permits new words to be fetched.
REQ-006 SHALL have port fifo_rempty  input  1: source FIFO empty; 1 = empty.
REQ-007 SHALL have port fifo_ren  output  1: source FIFO read strobe; 1 = read.
REQ-008 SHALL have port fifo_rdata  input  16: source data, valid the cycle after fifo_ren=1.
REQ-009 SHALL have port usb_flagc  input  1: CY68013 EP6 full flag; 1 = not full, 0 = full.
REQ-010 SHALL have port usb_fifoaddr  output  2: CY68013 FIFO address.
REQ-011 SHALL have port usb_slcs  output  1: chip select, active-low.
REQ-012 SHALL have port usb_sloe  output  1: slave output enable, active-low.
REQ-013 SHALL have port usb_slrd  output  1: read strobe, active-low.
REQ-014 SHALL have port usb_slwr  output  1: write strobe, active-low.
REQ-015 SHALL have port usb_pktend  output  1: packet end, active-low.
REQ-016 SHALL have port usb_fd_o  output  16: data driven to the CY68013.
REQ-017 SHALL have port usb_fd_oe  output  1: 1 = FPGA drives usb_fd.
REQ-018 SHALL have port tx_busy  output  1: 1 when state is not IDLE.
REQ-019 SHALL have port pkt_cnt  output  16: count of committed packets (full or short), wraps 0xFFFF to 0.

Function
REQ-020 SHALL tie usb_slcs=0, usb_sloe=1 and usb_slrd=1 at all times.
REQ-021 SHALL implement states IDLE, SETUP, RD, LD, WR, PKTEND.
REQ-022 SHALL move IDLE->SETUP when tx_en=1 and fifo_rempty=0.
REQ-023 SHALL, in IDLE, move to PKTEND when the word count is nonzero and the timeout counter equals FLUSH_TIMEOUT-1; this takes priority over REQ-022.
REQ-024 SHALL register usb_fifoaddr<=2'b10 (EP6) in SETUP, then move to RD.
REQ-025 SHALL drive fifo_ren=1 combinationally in RD only when fifo_rempty=0, then move to LD; if fifo_rempty=1 in RD, it SHALL move to IDLE with fifo_ren=0.
REQ-026 SHALL register usb_fd_o<=fifo_rdata in LD, then move to WR.
REQ-027 SHALL, in WR with usb_flagc=1, drive usb_slwr=0 for exactly that cycle and increment the word count; if the count was PKT_WORDS-1, the count SHALL become 0 and pkt_cnt SHALL increment.
REQ-028 SHALL, after a WR write cycle, go to RD if tx_en=1 and fifo_rempty=0, else to IDLE.
REQ-029 SHALL, in WR with usb_flagc=0, hold state, usb_fd_o and the word count, with usb_slwr=1.
REQ-030 SHALL, in PKTEND with usb_flagc=1, drive usb_pktend=0 for one cycle, clear the word count, increment pkt_cnt and go to IDLE; with usb_flagc=0 it SHALL wait with usb_pktend=1.
REQ-031 SHALL drive usb_slwr and usb_pktend combinationally from state and usb_flagc; neither may be 0 in the same cycle.
REQ-032 SHALL drive usb_fd_oe=1 in SETUP, RD, LD, WR and PKTEND, and 0 in IDLE.
REQ-033 SHALL increment a 16-bit timeout counter each IDLE cycle while the word count is nonzero; it SHALL clear on leaving IDLE or when the word count is 0.
REQ-034 SHALL keep the word count in the range 0..PKT_WORDS-1 and never emit a zero-length packet end.

Reset
REQ-035 SHALL, while rst_n=0, immediately force: state IDLE, usb_fifoaddr=2'b00, usb_fd_o=16'h0000, word count 0, timeout 0, pkt_cnt 0, fifo_ren=0, usb_slwr=1, usb_pktend=1, usb_fd_oe=0, tx_busy=0.
REQ-036 SHALL discard any word in flight when reset is asserted mid-transfer, with no slwr or pktend strobe on reset release.

Verification
REQ-037 SHALL cover single word: FIFO holds 16'hA5A5, tx_en=1, flagc=1 -> SETUP, RD (ren=1), LD, WR with slwr=0 and fd_o=A5A5; FLUSH_TIMEOUT IDLE cycles later pktend=0 for one cycle; pkt_cnt=1.
REQ-038 SHALL cover a full packet: 256 words 0..255 streamed -> 256 slwr pulses in order, no pktend, pkt_cnt=1, word count 0.
REQ-039 SHALL cover backpressure: flagc=0 during WR for 10 cycles -> slwr stays 1 and fd_o holds; one slwr pulse after flagc=1.
REQ-040 SHALL cover a blocked flush: flagc=0 at PKTEND entry -> pktend held 1 until flagc=1, then a single 0 pulse.
REQ-041 SHALL cover mid-transfer reset: rst_n=0 in LD -> all outputs take REQ-035 values in the same cycle; after release, no strobe until new data arrives.
REQ-042 SHALL cover FIFO empty at RD: fifo_rempty rises during WR -> transition WR->IDLE with no ren; a later refill resumes via SETUP.

Source files
------------

// File: rtl/cyp_ep6_wr_if.sv
// rtl/cyp_ep6_wr_if.sv - CY68013 slave-FIFO bus signals for the EP6 write path.
interface cyp_ep6_wr_if;
  logic        usb_flagc;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs;
  logic        usb_sloe;
  logic        usb_slrd;
  logic        usb_slwr;
  logic        usb_pktend;
  logic [15:0] usb_fd_o;
  logic        usb_fd_oe;

  modport master (
    input  usb_flagc,
    output usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr,
    output usb_pktend, usb_fd_o, usb_fd_oe
  );

  modport slave (
    output usb_flagc,
    input  usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr,
    input  usb_pktend, usb_fd_o, usb_fd_oe
  );
endinterface

// File: rtl/cyp_ep6_wr.sv
// rtl/cyp_ep6_wr.sv - streams 16-bit FIFO words into CY68013 EP6 with idle-timeout short-packet flush.
module cyp_ep6_wr #(
  parameter int PKT_WORDS     = 256,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic               cyp_clk,
  input  logic               rst_n,
  input  logic               tx_en,
  input  logic               fifo_rempty,
  output logic               fifo_ren,
  input  logic [15:0]        fifo_rdata,
  cyp_ep6_wr_if.master       usb,
  output logic               tx_busy,
  output logic [15:0]        pkt_cnt
);

  localparam int              WCW      = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
  localparam logic [WCW-1:0]  WC_LAST  = WCW'(PKT_WORDS - 1);
  localparam logic [15:0]     TMO_LAST = 16'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    RD     = 3'd2,
    LD     = 3'd3,
    WR     = 3'd4,
    PKTEND = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [WCW-1:0]  word_cnt;
  logic [15:0]     tmo_cnt;
  logic            wr_fire;
  logic            pe_fire;

  // Flush check wins over fetching so a stalled short packet is never starved.
  always_comb begin
    state_nxt = state;
    fifo_ren  = 1'b0;
    wr_fire   = 1'b0;
    pe_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (word_cnt != '0 && tmo_cnt == TMO_LAST)
          state_nxt = PKTEND;
        else if (tx_en && !fifo_rempty)
          state_nxt = SETUP;
      end
      SETUP: state_nxt = RD;
      RD: begin
        if (!fifo_rempty) begin
          fifo_ren  = 1'b1;
          state_nxt = LD;
        end else begin
          state_nxt = IDLE;
        end
      end
      LD: state_nxt = WR;
      WR: begin
        if (usb.usb_flagc) begin
          wr_fire   = 1'b1;
          state_nxt = (tx_en && !fifo_rempty) ? RD : IDLE;
        end
      end
      PKTEND: begin
        if (usb.usb_flagc) begin
          pe_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign usb.usb_slcs   = 1'b0;
  assign usb.usb_sloe   = 1'b1;
  assign usb.usb_slrd   = 1'b1;
  assign usb.usb_slwr   = ~wr_fire;
  assign usb.usb_pktend = ~pe_fire;
  assign usb.usb_fd_oe  = (state != IDLE);
  assign tx_busy        = (state != IDLE);

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge cyp_clk or negedge rst_n) begin
    if (!rst_n) begin
      usb.usb_fifoaddr <= 2'b00;
      usb.usb_fd_o     <= 16'h0000;
      word_cnt         <= '0;
      tmo_cnt          <= 16'h0000;
      pkt_cnt          <= 16'h0000;
    end else begin
      if (state == SETUP)
        usb.usb_fifoaddr <= 2'b10;
      if (state == LD)
        usb.usb_fd_o <= fifo_rdata;

      if (wr_fire)
        word_cnt <= (word_cnt == WC_LAST) ? '0 : word_cnt + 1'b1;
      else if (pe_fire)
        word_cnt <= '0;

      if ((wr_fire && word_cnt == WC_LAST) || pe_fire)
        pkt_cnt <= pkt_cnt + 16'h0001;

      // Counts only while a partial packet sits idle; any exit from IDLE restarts it.
      if (state == IDLE && state_nxt == IDLE && word_cnt != '0)
        tmo_cnt <= tmo_cnt + 16'h0001;
      else
        tmo_cnt <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_cyp_ep6_wr.sv
// tb/tb_cyp_ep6_wr.sv - directed self-checking bench for cyp_ep6_wr.
module tb_cyp_ep6_wr;
  localparam int PKT_WORDS = 256;
  localparam int FT        = 16;

  logic        cyp_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        tx_en   = 1'b0;
  logic        fifo_rempty;
  logic        fifo_ren;
  logic [15:0] fifo_rdata = 16'h0000;
  logic        tx_busy;
  logic [15:0] pkt_cnt;

  cyp_ep6_wr_if usb_if();

  cyp_ep6_wr #(.PKT_WORDS(PKT_WORDS), .FLUSH_TIMEOUT(FT)) dut (
    .cyp_clk     (cyp_clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .fifo_rempty (fifo_rempty),
    .fifo_ren    (fifo_ren),
    .fifo_rdata  (fifo_rdata),
    .usb         (usb_if.master),
    .tx_busy     (tx_busy),
    .pkt_cnt     (pkt_cnt)
  );

  always #10 cyp_clk = ~cyp_clk;

  logic [15:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  assign fifo_rempty = (wp == rp);

  always @(posedge cyp_clk) begin
    if (fifo_ren) begin
      fifo_rdata <= mem[rp];
      rp         <= rp + 1;
    end
  end

  logic [15:0] wr_log [0:1023];
  int nwr = 0;
  int npe = 0;
  bit overlap = 1'b0;

  always @(posedge cyp_clk) begin
    if (!usb_if.usb_slwr) begin
      wr_log[nwr] <= usb_if.usb_fd_o;
      nwr         <= nwr + 1;
    end
    if (!usb_if.usb_pktend)
      npe <= npe + 1;
    if (!usb_if.usb_slwr && !usb_if.usb_pktend)
      overlap <= 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cyp_clk);
    #2;
  endtask

  task automatic push(input logic [15:0] d);
    mem[wp] = d;
    wp = wp + 1;
  endtask

  typedef struct packed {
    logic        flagc;
    logic        ren;
    logic        slwr;
    logic        pktend;
    logic        busy;
    logic        fd_chk;
    logic [15:0] fd;
  } vec_t;

  vec_t vt [0:22];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int npe0;
    int nwr0;
    int bad;
    int budget;

    // Single-word transfer then timeout flush, one row per cycle.
    vt[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5};
    for (int i = 5; i < 5 + FT; i++)
      vt[i] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5};
    vt[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
    vt[22] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5A5};

    usb_if.usb_flagc = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ren",      fifo_ren, 0);
    chk("rst_slwr",     usb_if.usb_slwr, 1);
    chk("rst_pktend",   usb_if.usb_pktend, 1);
    chk("rst_oe",       usb_if.usb_fd_oe, 0);
    chk("rst_busy",     tx_busy, 0);
    chk("rst_fifoaddr", usb_if.usb_fifoaddr, 0);
    chk("rst_fd",       usb_if.usb_fd_o, 0);
    chk("rst_pkt_cnt",  pkt_cnt, 0);
    chk("tie_slcs",     usb_if.usb_slcs, 0);
    chk("tie_sloe",     usb_if.usb_sloe, 1);
    chk("tie_slrd",     usb_if.usb_slrd, 1);
    rst_n = 1'b1;
    tick();

    push(16'hA5A5);
    tx_en = 1'b1;
    for (int i = 0; i < 23; i++) begin
      usb_if.usb_flagc = vt[i].flagc;
      #1;
      chk($sformatf("vec%0d_ren", i),    fifo_ren, vt[i].ren);
      chk($sformatf("vec%0d_slwr", i),   usb_if.usb_slwr, vt[i].slwr);
      chk($sformatf("vec%0d_pktend", i), usb_if.usb_pktend, vt[i].pktend);
      chk($sformatf("vec%0d_busy", i),   tx_busy, vt[i].busy);
      chk($sformatf("vec%0d_oe", i),     usb_if.usb_fd_oe, vt[i].busy);
      if (vt[i].fd_chk)
        chk($sformatf("vec%0d_fd", i), usb_if.usb_fd_o, vt[i].fd);
      tick();
    end
    chk("single_pkt_cnt",  pkt_cnt, 1);
    chk("single_fifoaddr", usb_if.usb_fifoaddr, 2'b10);
    chk("single_nwr",      nwr, 1);
    chk("single_npe",      npe, 1);

    // Full packet: 256 words, no packet end.
    npe0 = npe;
    nwr0 = nwr;
    for (int i = 0; i < PKT_WORDS; i++)
      push(16'(i));
    budget = 0;
    while (!(nwr == nwr0 + PKT_WORDS && !tx_busy) && budget < 2000) begin
      tick();
      budget++;
    end
    chk("full_done_in_budget", (budget < 2000), 1);
    bad = 0;
    for (int i = 0; i < PKT_WORDS; i++)
      if (wr_log[nwr0 + i] !== 16'(i)) bad++;
    chk("full_order_bad", bad, 0);
    for (int i = 0; i < FT + 8; i++) tick();
    chk("full_no_pktend", npe, npe0);
    chk("full_pkt_cnt",   pkt_cnt, 2);
    chk("full_nwr",       nwr, nwr0 + PKT_WORDS);

    // Backpressure in WR, then a blocked flush.
    usb_if.usb_flagc = 1'b0;
    push(16'h1234);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp%0d_slwr", i), usb_if.usb_slwr, 1);
      chk($sformatf("bp%0d_fd", i),   usb_if.usb_fd_o, 16'h1234);
      chk($sformatf("bp%0d_busy", i), tx_busy, 1);
      tick();
    end
    nwr0 = nwr;
    usb_if.usb_flagc = 1'b1;
    #1;
    chk("bp_release_slwr", usb_if.usb_slwr, 0);
    tick();
    chk("bp_one_pulse", nwr, nwr0 + 1);
    chk("bp_log",       wr_log[nwr0], 16'h1234);
    chk("bp_idle",      tx_busy, 0);
    usb_if.usb_flagc = 1'b0;
    npe0 = npe;
    for (int i = 0; i < FT; i++) tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("pe_hold%0d_pktend", i), usb_if.usb_pktend, 1);
      chk($sformatf("pe_hold%0d_busy", i),   tx_busy, 1);
      tick();
    end
    usb_if.usb_flagc = 1'b1;
    #1;
    chk("pe_release_pktend", usb_if.usb_pktend, 0);
    tick();
    chk("pe_idle",    tx_busy, 0);
    chk("pe_pkt_cnt", pkt_cnt, 3);
    chk("pe_single",  npe, npe0 + 1);

    // Reset while LD holds a fetched word.
    push(16'hBEEF);
    for (int i = 0; i < 3; i++) tick();
    chk("mr_busy_before", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_ren",      fifo_ren, 0);
    chk("mr_slwr",     usb_if.usb_slwr, 1);
    chk("mr_pktend",   usb_if.usb_pktend, 1);
    chk("mr_oe",       usb_if.usb_fd_oe, 0);
    chk("mr_busy",     tx_busy, 0);
    chk("mr_fifoaddr", usb_if.usb_fifoaddr, 0);
    chk("mr_fd",       usb_if.usb_fd_o, 0);
    chk("mr_pkt_cnt",  pkt_cnt, 0);
    tick();
    rst_n = 1'b1;
    nwr0 = nwr;
    npe0 = npe;
    for (int i = 0; i < FT + 14; i++) tick();
    chk("mr_no_slwr",   nwr, nwr0);
    chk("mr_no_pktend", npe, npe0);
    chk("mr_idle",      tx_busy, 0);

    // FIFO runs dry during WR, then refills.
    push(16'h0C0C);
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("dry_wr_slwr", usb_if.usb_slwr, 0);
    tick();
    chk("dry_idle_busy", tx_busy, 0);
    chk("dry_idle_ren",  fifo_ren, 0);
    tick();
    tick();
    chk("dry_still_idle", tx_busy, 0);
    push(16'h0D0D);
    #1;
    chk("refill_idle_ren", fifo_ren, 0);
    tick();
    chk("refill_setup_busy", tx_busy, 1);
    chk("refill_setup_ren",  fifo_ren, 0);
    tick();
    chk("refill_rd_ren", fifo_ren, 1);
    tick();
    tick();
    #1;
    chk("refill_wr_slwr", usb_if.usb_slwr, 0);
    chk("refill_wr_fd",   usb_if.usb_fd_o, 16'h0D0D);
    tick();
    for (int i = 0; i < FT + 4; i++) tick();
    chk("refill_pkt_cnt", pkt_cnt, 1);
    chk("refill_log0",    wr_log[nwr - 2], 16'h0C0C);
    chk("refill_log1",    wr_log[nwr - 1], 16'h0D0D);

    chk("no_strobe_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
